// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 800x600@60 timing defaults shared by the sync generator and pixel pipelines
package vga_timing_pkg;
  function automatic int span(input int s, input int bp, input int act, input int fp);
    return s + bp + act + fp;
  endfunction
  localparam int VGA_H_SYNC  = 128;
  localparam int VGA_H_BP    = 88;
  localparam int VGA_H_ACT   = 800;
  localparam int VGA_H_FP    = 40;
  localparam int VGA_V_SYNC  = 4;
  localparam int VGA_V_BP    = 23;
  localparam int VGA_V_ACT   = 600;
  localparam int VGA_V_FP    = 1;
  localparam int VGA_H_TOTAL = span(VGA_H_SYNC, VGA_H_BP, VGA_H_ACT, VGA_H_FP);
  localparam int VGA_V_TOTAL = span(VGA_V_SYNC, VGA_V_BP, VGA_V_ACT, VGA_V_FP);
endpackage

// File: rtl/vga_sync.sv
// vga_sync: column/line counters with registered active-low sync pulses
module vga_sync
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP   = VGA_H_BP,
  parameter int H_ACT  = VGA_H_ACT,
  parameter int H_FP   = VGA_H_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP   = VGA_V_BP,
  parameter int V_ACT  = VGA_V_ACT,
  parameter int V_FP   = VGA_V_FP
) (
  input  logic        clk,
  input  logic        rst,
  output logic        hsync,
  output logic        vsync,
  output logic [10:0] c1,
  output logic [10:0] c2
);
  localparam int H_TOTAL = span(H_SYNC, H_BP, H_ACT, H_FP);
  localparam int V_TOTAL = span(V_SYNC, V_BP, V_ACT, V_FP);
  logic        h_end;
  logic [10:0] c1_nxt, c2_nxt;
  always_comb begin
    h_end  = c1 == 11'(H_TOTAL - 1);
    c1_nxt = h_end ? 11'd0 : c1 + 11'd1;
    c2_nxt = !h_end ? c2 : (c2 == 11'(V_TOTAL - 1)) ? 11'd0 : c2 + 11'd1;
  end
  // syncs decode the next counter values so they stay cycle-aligned with c1/c2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c1    <= '0;
      c2    <= '0;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else begin
      c1    <= c1_nxt;
      c2    <= c2_nxt;
      hsync <= c1_nxt >= 11'(H_SYNC);
      vsync <= c2_nxt >= 11'(V_SYNC);
    end
  end
endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: directed checks on a default-timing instance and a shrunken-timing instance
module tb_vga_sync;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic hs_a, vs_a, hs_b, vs_b;
  logic [10:0] c1a, c2a, c1b, c2b;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  vga_sync dut_a (.clk(clk), .rst(rst_a), .hsync(hs_a), .vsync(vs_a), .c1(c1a), .c2(c2a));
  // 19-clock lines, 11-line frames: 209-clock frame keeps vertical checks short
  vga_sync #(.H_SYNC(4), .H_BP(3), .H_ACT(10), .H_FP(2),
             .V_SYNC(2), .V_BP(3), .V_ACT(5), .V_FP(1))
    dut_b (.clk(clk), .rst(rst_b), .hsync(hs_b), .vsync(vs_b), .c1(c1b), .c2(c2b));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic wait_a(input int x, input int y, input string tag);
    int n = 0;
    while (!(c1a == 11'(x) && c2a == 11'(y)) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(c1a == 11'(x) && c2a == 11'(y)), 1);
  endtask
  task automatic wait_b(input int x, input int y, input string tag);
    int n = 0;
    while (!(c1b == 11'(x) && c2b == 11'(y)) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(c1b == 11'(x) && c2b == 11'(y)), 1);
  endtask
  initial begin
    int cnt, per;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (40) begin
      @(negedge clk);
      chk("rst c1", c1a, 0);
      chk("rst c2", c2a, 0);
      chk("rst hsync", hs_a, 0);
      chk("rst vsync", vs_a, 0);
    end
    rst_a = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("post-rst c1", c1a, k);
      chk("post-rst c2", c2a, 0);
    end
    wait_a(127, 0, "reach c1=127");
    chk("hsync at 127", hs_a, 0);
    @(negedge clk);
    chk("c1 at 128", c1a, 128);
    chk("hsync at 128", hs_a, 1);
    chk("c2 held mid-line", c2a, 0);
    wait_a(1055, 0, "reach c1=1055");
    chk("hsync at 1055", hs_a, 1);
    @(negedge clk);
    chk("line wrap c1", c1a, 0);
    chk("line wrap c2", c2a, 1);
    chk("hsync at wrap", hs_a, 0);
    cnt = 0;
    while (hs_a == 1'b0 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    chk("hsync low width", cnt, 128);
    per = cnt;
    while (hs_a == 1'b1 && per < 3000) begin
      @(negedge clk);
      per++;
    end
    chk("hsync period", per, 1056);
    chk("c2 after one line", c2a, 2);
    wait_a(1055, 3, "reach line 3 end");
    chk("vsync on line 3", vs_a, 0);
    @(negedge clk);
    chk("c2 becomes 4", c2a, 4);
    chk("vsync rises at c2=4", vs_a, 1);
    wait_a(500, 4, "reach mid-line");
    rst_a = 1'b1;
    #1;
    chk("async rst c1", c1a, 0);
    chk("async rst c2", c2a, 0);
    chk("async rst hsync", hs_a, 0);
    chk("async rst vsync", vs_a, 0);
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    chk("resume c1", c1a, 1);
    chk("resume c2", c2a, 0);
    rst_b = 1'b0;
    wait_b(18, 10, "reach frame end");
    chk("vsync frame end", vs_b, 1);
    @(negedge clk);
    chk("frame wrap c1", c1b, 0);
    chk("frame wrap c2", c2b, 0);
    chk("frame wrap vsync", vs_b, 0);
    chk("frame wrap hsync", hs_b, 0);
    cnt = 0;
    while (vs_b == 1'b0 && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    chk("vsync low width", cnt, 38);
    chk("vsync rise c2", c2b, 2);
    per = 0;
    while (vs_b == 1'b1 && per < 500) begin
      @(negedge clk);
      per++;
    end
    while (vs_b == 1'b0 && per < 500) begin
      @(negedge clk);
      per++;
    end
    chk("vsync period", per, 209);
    wait_b(9, 5, "reach mid-frame");
    rst_b = 1'b1;
    #1;
    chk("mid-frame rst c1", c1b, 0);
    chk("mid-frame rst c2", c2b, 0);
    chk("mid-frame rst hsync", hs_b, 0);
    chk("mid-frame rst vsync", vs_b, 0);
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    chk("mid-frame resume c1", c1b, 1);
    chk("mid-frame resume c2", c2b, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
